// File: rtl/secure_auth_pkg.sv
// secure_auth_pkg: shared types, defaults, LFSR taps and keyed digest for the secure-unlock initiator.
// Rev 1.0
`default_nettype none

package secure_auth_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ISSUE     = 3'd1,
      WAIT_RSP  = 3'd2,
      RESET_RSP = 3'd3,
      DONE      = 3'd4,
      FAIL      = 3'd5
   } auth_state_t;

   localparam int DEF_CHAL_W        = 4;
   localparam int DEF_SIG_W         = 8;
   localparam int DEF_TIMEOUT_CYC   = 16;
   localparam int DEF_MAX_RETRY     = 3;
   localparam int DEF_RST_PULSE_CYC = 2;
   localparam int DEF_LFSR_SEED     = 9;
   localparam int DEF_LOCKOUT_CYC   = 64;

   localparam int DIGEST_MAXW = 64;

   // x^4 + x^3 + 1: feedback is bit3 ^ bit2 of a left-shifting register.
   localparam logic [3:0] LFSR4_TAPS = 4'b1100;

   // Maximal-length taps so a nonzero seed can never reach the all-zero state.
   function automatic logic [31:0] lfsr_taps(input int width);
      case (width)
         3:       return 32'h0000_0006;
         4:       return {28'd0, LFSR4_TAPS};
         5:       return 32'h0000_0014;
         6:       return 32'h0000_0030;
         7:       return 32'h0000_0060;
         8:       return 32'h0000_00B8;
         16:      return 32'h0000_B400;
         default: return {28'd0, LFSR4_TAPS};
      endcase
   endfunction

   // rotl(key, chal[2:0]) XOR the challenge replicated across the key width.
   function automatic logic [DIGEST_MAXW-1:0] auth_digest(
      input logic [DIGEST_MAXW-1:0] key,
      input logic [DIGEST_MAXW-1:0] chal,
      input int                     sig_w,
      input int                     chal_w
   );
      logic [DIGEST_MAXW-1:0] d;
      int                     rot;
      d   = '0;
      rot = int'(chal[2:0]) % sig_w;
      for (int i = 0; i < sig_w; i++) begin
         d[(i + rot) % sig_w] = key[i];
      end
      for (int i = 0; i < sig_w; i++) begin
         d[i] = d[i] ^ chal[i % chal_w];
      end
      return d;
   endfunction

endpackage

`default_nettype wire

// File: rtl/auth_lfsr.sv
// auth_lfsr: free-running, seeded, enable-less Fibonacci LFSR used as the challenge source.
// Rev 1.0
`default_nettype none

module auth_lfsr
   import secure_auth_pkg::*;
#(
   parameter int               WIDTH = DEF_CHAL_W,
   parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEF_LFSR_SEED)
) (
   input  logic             clk,
   input  logic             resetn,
   output logic [WIDTH-1:0] value
);

   localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

   logic feedback;

   assign feedback = ^(value & TAPS);

   // The zero check only matters after an upset; it keeps the never-zero guarantee unconditional.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         value <= SEED;
      end else if (value == '0) begin
         value <= SEED;
      end else begin
         value <= {value[WIDTH-2:0], feedback};
      end
   end

endmodule

`default_nettype wire

// File: rtl/secure_auth_initiator.sv
// secure_auth_initiator: host-side driver of the secure-unlock handshake with retry and responder recovery.
// Rev 1.0 -- optional post-failure lockout enabled by defining SEC_AUTH_LOCKOUT_EN.
`default_nettype none

module secure_auth_initiator
   import secure_auth_pkg::*;
#(
   parameter int                CHAL_W        = DEF_CHAL_W,
   parameter int                SIG_W         = DEF_SIG_W,
   parameter int                TIMEOUT_CYC   = DEF_TIMEOUT_CYC,
   parameter int                MAX_RETRY     = DEF_MAX_RETRY,
   parameter int                RST_PULSE_CYC = DEF_RST_PULSE_CYC,
   parameter logic [CHAL_W-1:0] LFSR_SEED     = CHAL_W'(DEF_LFSR_SEED),
   parameter int                LOCKOUT_CYC   = DEF_LOCKOUT_CYC,
   localparam int               RCW           = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              auth_req_i,
   input  logic              auth_clear_i,
   input  logic [SIG_W-1:0]  auth_key_i,
   input  logic [SIG_W-1:0]  golden_tag_i,
   input  logic              rsp_locked_i,
   input  logic              rsp_error_i,
   input  logic              rsp_secure_i,
   output logic              write_enable_o,
   output logic [CHAL_W-1:0] challenge_o,
   output logic              sig_o,
   output logic              rsp_resetn_o,
   output logic              auth_busy_o,
   output logic              auth_done_o,
   output logic              auth_fail_o,
   output logic [RCW-1:0]    retry_cnt_o,
   output logic              lockout_o
);

   localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int PW = (RST_PULSE_CYC > 1) ? $clog2(RST_PULSE_CYC) : 1;

   localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [PW-1:0]  PULSE_LAST = PW'(RST_PULSE_CYC - 1);
   localparam logic [RCW-1:0] RETRY_MAX  = RCW'(MAX_RETRY);

   auth_state_t       state;
   logic [CHAL_W-1:0] lfsr;
   logic [TW-1:0]     timer;
   logic [PW-1:0]     pulse_cnt;
   logic              ret_idle;
   logic              digest_ok;
   logic              clear_ok;
   logic              unused_status;

   // Locked status is informational only; the handshake is driven by error and secure.
   assign unused_status = rsp_locked_i;

   auth_lfsr #(
      .WIDTH (CHAL_W),
      .SEED  (LFSR_SEED)
   ) u_lfsr (
      .clk    (clk),
      .resetn (resetn),
      .value  (lfsr)
   );

   assign digest_ok = (SIG_W'(auth_digest(DIGEST_MAXW'(auth_key_i), DIGEST_MAXW'(lfsr), SIG_W, CHAL_W))
                       == golden_tag_i);

`ifdef SEC_AUTH_LOCKOUT_EN
   localparam int             LW        = $clog2(LOCKOUT_CYC + 1);
   localparam logic [LW-1:0]  LOCK_LOAD = LW'(LOCKOUT_CYC);

   logic [LW-1:0] lock_cnt;

   assign lockout_o = (lock_cnt != '0);
   assign clear_ok  = auth_clear_i && (lock_cnt == '0);
`else
   localparam int unused_lockout_cyc = LOCKOUT_CYC;

   assign lockout_o = 1'b0;
   assign clear_ok  = auth_clear_i;
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state          <= IDLE;
         challenge_o    <= '0;
         sig_o          <= 1'b0;
         write_enable_o <= 1'b0;
         rsp_resetn_o   <= 1'b1;
         auth_busy_o    <= 1'b0;
         auth_done_o    <= 1'b0;
         auth_fail_o    <= 1'b0;
         retry_cnt_o    <= '0;
         timer          <= '0;
         pulse_cnt      <= '0;
         ret_idle       <= 1'b0;
`ifdef SEC_AUTH_LOCKOUT_EN
         lock_cnt       <= '0;
`endif
      end else begin
         write_enable_o <= 1'b0;
`ifdef SEC_AUTH_LOCKOUT_EN
         if (lock_cnt != '0) lock_cnt <= lock_cnt - 1'b1;
`endif
         case (state)
            IDLE: begin
               if (auth_req_i) begin
                  challenge_o    <= lfsr;
                  sig_o          <= digest_ok;
                  write_enable_o <= 1'b1;
                  auth_busy_o    <= 1'b1;
                  state          <= ISSUE;
               end
            end
            ISSUE: begin
               timer <= '0;
               state <= WAIT_RSP;
            end
            WAIT_RSP: begin
               // Error outranks secure, and any status outranks the timeout on the same cycle.
               if (rsp_error_i || (!rsp_secure_i && timer == TIMER_LAST)) begin
                  if (retry_cnt_o < RETRY_MAX) begin
                     retry_cnt_o  <= retry_cnt_o + 1'b1;
                     ret_idle     <= 1'b0;
                     pulse_cnt    <= '0;
                     rsp_resetn_o <= 1'b0;
                     state        <= RESET_RSP;
                  end else begin
                     auth_busy_o <= 1'b0;
                     auth_fail_o <= 1'b1;
                     state       <= FAIL;
`ifdef SEC_AUTH_LOCKOUT_EN
                     lock_cnt    <= LOCK_LOAD;
`endif
                  end
               end else if (rsp_secure_i) begin
                  auth_busy_o <= 1'b0;
                  auth_done_o <= 1'b1;
                  state       <= DONE;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            RESET_RSP: begin
               if (pulse_cnt == PULSE_LAST) begin
                  rsp_resetn_o <= 1'b1;
                  if (ret_idle) begin
                     auth_busy_o <= 1'b0;
                     challenge_o <= '0;
                     sig_o       <= 1'b0;
                     state       <= IDLE;
                  end else begin
                     challenge_o    <= lfsr;
                     sig_o          <= digest_ok;
                     write_enable_o <= 1'b1;
                     state          <= ISSUE;
                  end
               end else begin
                  pulse_cnt <= pulse_cnt + 1'b1;
               end
            end
            DONE, FAIL: begin
               if (clear_ok) begin
                  retry_cnt_o  <= '0;
                  auth_done_o  <= 1'b0;
                  auth_fail_o  <= 1'b0;
                  auth_busy_o  <= 1'b1;
                  ret_idle     <= 1'b1;
                  pulse_cnt    <= '0;
                  rsp_resetn_o <= 1'b0;
                  state        <= RESET_RSP;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire
